// File: rtl/alu_result_display_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_display_if
// Purpose  : Bundles the ALU result input and the 7-segment display outputs
//            shared between the ALU test harness and the display driver.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_result_display_if;
  logic [9:0] result;  // ALU result, unsigned
  logic [6:0] seg;     // active-low segments {g,f,e,d,c,b,a}
  logic [3:0] an;      // active-low one-hot digit enables
  logic       busy;    // conversion in progress

  // Producer of the ALU result; observes the display lines.
  modport master (
    output result,
    input  seg,
    input  an,
    input  busy
  );

  // Display driver.
  modport slave (
    input  result,
    output seg,
    output an,
    output busy
  );
endinterface
`default_nettype wire

// File: rtl/alu_result_display.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_display
// Purpose  : Converts a 10-bit ALU result to four BCD digits with a
//            sequential double-dabble engine and time-multiplexes them onto
//            a 4-digit common-anode 7-segment display.
// Options  : ALU_DISP_LZB_EN - when defined, leading zeros are blanked.
// Revision : 1.0 - initial release
// ============================================================================
module alu_result_display #(
  parameter int REFRESH_DIV = 50000  // cycles each digit stays lit, >= 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_result_display_if.slave   bus
);

  localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(REFRESH_DIV - 1);
  localparam logic [3:0] LAST_BIT = 4'd9;  // cnt value on the 10th shift

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [9:0]       last_val;
  logic [9:0]       sh;
  logic [15:0]      bcd;
  logic [15:0]      bcd_adj;
  logic [15:0]      disp;
  logic [3:0]       cnt;
  logic [DIV_W-1:0] div;
  logic [1:0]       idx;
  logic [3:0]       digit;
  logic [6:0]       seg_raw;
  logic             start;

  // A new conversion is launched only when the input differs from the last
  // accepted value; this also catches changes that arrived mid-conversion.
  assign start = (bus.result != last_val);

  // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
  for (genvar i = 0; i < 4; i++) begin : g_adj
    assign bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3
                                                       : bcd[4*i +: 4];
  end

  // Conversion FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Conversion FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CONV;
      CONV:    if (cnt == LAST_BIT) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Conversion datapath: load on start, adjust-and-shift in CONV, publish in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_val <= '0;
      sh       <= '0;
      bcd      <= '0;
      cnt      <= '0;
      disp     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sh       <= bus.result;
            last_val <= bus.result;
            bcd      <= '0;
            cnt      <= '0;
          end
        end
        CONV: begin
          {bcd, sh} <= {bcd_adj, sh} << 1;
          cnt       <= cnt + 4'd1;
        end
        DONE: begin
          disp <= bcd;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);

  // Refresh divider and digit scanner; free-running, independent of conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      idx <= '0;
    end else if (div == DIV_MAX) begin
      div <= '0;
      idx <= idx + 2'd1;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  assign digit  = disp[4*idx +: 4];
  assign bus.an = ~(4'b0001 << idx);

  // BCD to active-low 7-segment decode, bit order {g,f,e,d,c,b,a}.
  always_comb begin
    seg_raw = 7'b1111111;
    case (digit)
      4'd0:    seg_raw = 7'b1000000;
      4'd1:    seg_raw = 7'b1111001;
      4'd2:    seg_raw = 7'b0100100;
      4'd3:    seg_raw = 7'b0110000;
      4'd4:    seg_raw = 7'b0011001;
      4'd5:    seg_raw = 7'b0010010;
      4'd6:    seg_raw = 7'b0000010;
      4'd7:    seg_raw = 7'b1111000;
      4'd8:    seg_raw = 7'b0000000;
      4'd9:    seg_raw = 7'b0010000;
      default: seg_raw = 7'b1111111;
    endcase
  end

`ifdef ALU_DISP_LZB_EN
  // A digit is blank when it and every more significant digit are zero;
  // the units digit always shows.
  logic [3:0] blank;
  assign blank[3] = (disp[15:12] == 4'd0);
  assign blank[2] = blank[3] && (disp[11:8] == 4'd0);
  assign blank[1] = blank[2] && (disp[7:4] == 4'd0);
  assign blank[0] = 1'b0;
  assign bus.seg  = blank[idx] ? 7'b1111111 : seg_raw;
`else
  assign bus.seg  = seg_raw;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_result_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_result_display
// Purpose  : Directed self-checking bench for alu_result_display with
//            REFRESH_DIV = 4. Honours ALU_DISP_LZB_EN for blanking checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_result_display;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   tk;  // edges since the last reset release

  alu_result_display_if bus ();

  alu_result_display #(.REFRESH_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    tk++;
  endtask

  // Wait (bounded) for digit d to be lit, then check its segments.
  task automatic show_digit(input int d, input logic [6:0] exp_seg, input string tag);
    logic [3:0] want;
    want = ~(4'b0001 << d);
    for (int i = 0; i < 20 && bus.an !== want; i++) tick();
    check({tag, "_an"}, 16'(bus.an), 16'(want));
    check(tag, 16'(bus.seg), 16'(exp_seg));
  endtask

  // Apply a value from IDLE and check the 12-edge conversion timeline.
  task automatic convert(input logic [9:0] v, input logic [15:0] exp_bcd,
                         input logic [15:0] old_disp, input string tag);
    bus.result = v;
    tick();
    check({tag, "_busy_e1"}, 16'(bus.busy), 16'd1);
    repeat (10) tick();
    check({tag, "_busy_e11"}, 16'(bus.busy), 16'd1);
    check({tag, "_disp_e11"}, dut.disp, old_disp);
    tick();
    check({tag, "_busy_e12"}, 16'(bus.busy), 16'd0);
    check({tag, "_disp_e12"}, dut.disp, exp_bcd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic [6:0] lead_zero;
    n_checks   = 0;
    n_fail     = 0;
    tk         = 0;
    rst_n      = 1'b0;
    bus.result = 10'd0;
`ifdef ALU_DISP_LZB_EN
    lead_zero = SEG_BLANK;
`else
    lead_zero = SEG_0;
`endif

    // Reset state.
    repeat (3) tick();
    check("rst_busy", 16'(bus.busy), 16'd0);
    check("rst_an", 16'(bus.an), 16'b1110);
    check("rst_seg", 16'(bus.seg), 16'(SEG_0));
    check("rst_disp", dut.disp, 16'h0000);

    // Release with result 0: no conversion, scanner walks all four digits.
    rst_n = 1'b1;
    tk    = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      exp_an  = ~(4'b0001 << ((tk / 4) % 4));
      exp_seg = (exp_an == 4'b1110) ? SEG_0 : lead_zero;
      check("scan_busy", 16'(bus.busy), 16'd0);
      check("scan_an", 16'(bus.an), 16'(exp_an));
      check("scan_seg", 16'(bus.seg), 16'(exp_seg));
    end

    // Single-digit value.
    convert(10'd5, 16'h0005, 16'h0000, "c5");
    show_digit(0, SEG_5, "c5_d0");

    // Full-scale value.
    convert(10'd1023, 16'h1023, 16'h0005, "c1023");
    show_digit(3, SEG_1, "c1023_d3");
    show_digit(2, SEG_0, "c1023_d2");
    show_digit(1, SEG_2, "c1023_d1");
    show_digit(0, SEG_3, "c1023_d0");

    // Change during conversion: 30 then 7 at edge 4.
    bus.result = 10'd30;
    tick();
    check("b2b_busy_e1", 16'(bus.busy), 16'd1);
    repeat (2) tick();
    bus.result = 10'd7;
    repeat (9) tick();
    check("b2b_busy_e12", 16'(bus.busy), 16'd0);
    check("b2b_disp_e12", dut.disp, 16'h0030);
    tick();
    check("b2b_busy_e13", 16'(bus.busy), 16'd1);
    repeat (10) tick();
    check("b2b_disp_e23", dut.disp, 16'h0030);
    tick();
    check("b2b_busy_e24", 16'(bus.busy), 16'd0);
    check("b2b_disp_e24", dut.disp, 16'h0007);

    // Reset mid-conversion of 999.
    bus.result = 10'd999;
    repeat (5) tick();
    check("mid_busy_pre", 16'(bus.busy), 16'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 16'(bus.busy), 16'd0);
    check("mid_rst_disp", dut.disp, 16'h0000);
    check("mid_rst_an", 16'(bus.an), 16'b1110);
    check("mid_rst_seg", 16'(bus.seg), 16'(SEG_0));
    tick();
    check("mid_rst_hold", dut.disp, 16'h0000);
    rst_n = 1'b1;
    tk    = 0;
    convert(10'd999, 16'h0999, 16'h0000, "c999");

    // Leading-zero behaviour with 30 and with 0.
    convert(10'd30, 16'h0030, 16'h0999, "c30");
    show_digit(3, lead_zero, "c30_d3");
    show_digit(2, lead_zero, "c30_d2");
    show_digit(1, SEG_3, "c30_d1");
    show_digit(0, SEG_0, "c30_d0");

    convert(10'd0, 16'h0000, 16'h0030, "c0");
    show_digit(3, lead_zero, "c0_d3");
    show_digit(2, lead_zero, "c0_d2");
    show_digit(1, lead_zero, "c0_d1");
    show_digit(0, SEG_0, "c0_d0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_result_display.md
# alu_result_display

Drives a 4-digit, common-anode 7-segment display with the 10-bit `ALURes` value produced by the board-level ALU test module. It sits on the output side of the ALU, after the switch-driven `A`/`B`/`ALUOp` inputs.
- Converts the binary result (0..1023) to four BCD digits with a sequential double-dabble engine.
- Time-multiplexes the digits onto shared segment lines.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each digit stays lit; legal range ≥2.
- `clk`  in  1: single clock; all state on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `result`  in  10: ALU result, unsigned, sampled synchronously.
- `seg`  out  7: segments, active-low, bit order {g,f,e,d,c,b,a}.
- `an`  out  4: digit enables, active-low one-hot; bit 0 = units, bit 3 = thousands.
- `busy`  out  1: high while a conversion is in progress.

## Operation
- Registers:
  - `last_val[9:0]`: last value accepted for conversion.
  - `sh[9:0]`: conversion shift register.
  - `bcd[15:0]`: conversion accumulator.
  - `disp[15:0]`: BCD digits currently displayed.
  - `cnt[3:0]`: conversion bit counter.
  - `div`: refresh counter.
  - `idx[1:0]`: digit currently lit.
- Conversion FSM states:
  - IDLE: if `result != last_val`, set `sh<=result`, `last_val<=result`, `bcd<=0`, `cnt<=0`, go to CONV. Otherwise stay.
  - CONV: each cycle, add 3 to every BCD nibble ≥5, then shift {bcd,sh} left by 1. Increment `cnt`. After the 10th shift (`cnt==9`), go to DONE.
  - DONE: `disp<=bcd`, go to IDLE.
- `result` is ignored during CONV and DONE. A change that arrives during conversion is caught in the next IDLE cycle by the `last_val` compare. The intermediate value is displayed first, then the new value.
- `busy` = (state != IDLE).
- Scanner:
  - `div` counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, `idx` increments modulo 4 (3 wraps to 0).
  - `an` = ~(4'b0001 << idx).
  - `seg` = decode(`disp[4*idx +: 4]`).
- Decode (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any other nibble value = 1111111 (unreachable).
- `seg` and `an` are pure decodes of registered `idx`/`disp`. No glitch-free requirement beyond that.

## Timing
- Reset values: state=IDLE, `last_val`=0, `disp`=0, `idx`=0, `div`=0, `cnt`=0. Outputs: `an`=1110, `seg`=1000000 (units shows "0"), `busy`=0.
- A `result` of 0 after reset triggers no conversion.
- Latency, with edge 1 = the edge sampling a new `result` in IDLE:
  - `busy` rises after edge 1.
  - CONV covers edges 2..11.
  - `disp` updates at edge 12, where `busy` falls.
  - `seg` reflects the new digit on the following cycle for whichever digit is lit.
- Back-to-back changes: the minimum conversion period is 12 cycles. Any changes beyond one pending value collapse; the latest value seen in IDLE wins.
- Reset asserted mid-conversion: aborts immediately to reset values. `disp` is not updated with partial results.
- Scan period is 4·REFRESH_DIV cycles. Conversion does not disturb `div` or `idx`.

## Configuration
- `ALU_DISP_LZB_EN` defined: leading-zero blanking.
  - Digit 3 is blank when zero.
  - Digit 2 is blank when it and digit 3 are zero.
  - Digit 1 is blank when it and digits 2 and 3 are zero.
  - Digit 0 is never blanked.
  - A blank digit drives `seg`=1111111; `an` still scans normally.
- `ALU_DISP_LZB_EN` undefined: all four digits always shown, including leading zeros.

## Test plan
All scenarios use REFRESH_DIV=4.
- Reset release, `result`=0 -> `busy` stays 0; `an` cycles 1110,1101,1011,0111, 4 cycles each; `seg`=1000000 on every digit (macro off).
- `result`=5 -> `busy` high for edges 2..12; `disp`=0005 at edge 12; when `an`=1110, `seg`=0010010.
- `result`=1023 -> `disp`=1023. Digits 3..0 give `seg` = 1111001, 1000000, 0100100, 0110000.
- `result`=30, then `result`=7 at edge 4 -> `disp`=0030 at edge 12; new conversion starts at edge 13; `disp`=0007 at edge 24.
- `result`=999, `rst_n` pulsed low at edge 6 -> immediate reset values. `disp`=0 and `busy`=0 during reset. After release, 999 is reconverted and `disp`=0999 12 edges later.
- Macro on, `result`=30 -> digits 3 and 2 show `seg`=1111111; digit 1 = 0110000; digit 0 = 1000000. With `result`=0, digit 0 = 1000000 and the others are blank.
